// File: rtl/tiny_proc_loader_if.sv
// Command/response handshake plus processor load/run pins for tiny_proc_loader.
// slave: the loader side; master: the host/harness side.
interface tiny_proc_loader_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_timeout;
  logic       mosi;
  logic       csi_n;
  logic       csd_n;
  logic       proc_en;
  logic       proc_done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, proc_done,
    output cmd_ready, rsp_valid, rsp_timeout, mosi, csi_n, csd_n, proc_en
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, proc_done,
    input  cmd_ready, rsp_valid, rsp_timeout, mosi, csi_n, csd_n, proc_en
  );
endinterface

// File: rtl/tiny_proc_loader.sv
// Serial load/run master for the tiny processor; optional run watchdog under LOADER_TIMEOUT_EN.
// Latency: write -> rsp_valid 15 cycles (GAP_CYCLES=2); run -> rsp_valid the cycle after proc_done sampled high.
// Backpressure: cmd_ready only in IDLE; one command in flight, cmd_* ignored while busy.
module tiny_proc_loader #(
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255,
  parameter int TIMEOUT_W  = 8
) (
  input logic             clk,
  input logic             rst_n,
  tiny_proc_loader_if.slave bus
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT, GAP, RUN_BUSY, RUN_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [11:0]        frame;
  logic               sel_d;
  logic [3:0]         bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               run_q;
  logic               rsp_vld_q;
  logic               rsp_tmo_q;
  logic               rsp_set;
  logic               tmo_set;
  logic               accept;
  logic               tmo_hit;

  assign bus.cmd_ready = (state == IDLE) && rst_n;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

`ifdef LOADER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Hit on the edge where the count would reach TIMEOUT.
  assign tmo_hit = (tmo_cnt == TIMEOUT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (accept && bus.cmd_op == 2'b10) begin
      tmo_cnt <= '0;
    end else if (state == RUN_BUSY || state == RUN_DONE) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    rsp_set   = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            2'b00, 2'b01: state_nxt = SHIFT;
            2'b10:        state_nxt = RUN_BUSY;
            default:      rsp_set   = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        if (bit_cnt == 4'd11) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          rsp_set   = 1'b1;
        end
      end
      RUN_BUSY: begin
        if (tmo_hit) begin
          state_nxt = IDLE;
          rsp_set   = 1'b1;
          tmo_set   = 1'b1;
        end else if (!bus.proc_done) begin
          state_nxt = RUN_DONE;
        end
      end
      RUN_DONE: begin
        // Completion takes priority over a watchdog hit on the same edge.
        if (bus.proc_done) begin
          state_nxt = IDLE;
          rsp_set   = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          rsp_set   = 1'b1;
          tmo_set   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame     <= '0;
      sel_d     <= 1'b0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      run_q     <= 1'b0;
      rsp_vld_q <= 1'b0;
      rsp_tmo_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_vld_q <= rsp_set;
      rsp_tmo_q <= tmo_set;
      run_q     <= (state_nxt == RUN_BUSY) || (state_nxt == RUN_DONE);
      bit_cnt   <= (state == SHIFT) ? bit_cnt + 1'b1 : 4'd0;
      gap_cnt   <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (accept && !bus.cmd_op[1]) begin
        frame <= {bus.cmd_data, bus.cmd_addr};
        sel_d <= bus.cmd_op[0];
      end
    end
  end

  assign bus.mosi    = (state == SHIFT) ? frame[bit_cnt] : 1'b0;
  assign bus.csi_n   = !((state == SHIFT) && !sel_d);
  assign bus.csd_n   = !((state == SHIFT) && sel_d);
  // Gating on proc_done drops enable the same cycle the processor goes idle.
  assign bus.proc_en = run_q && ((state == RUN_BUSY) ||
                                 ((state == RUN_DONE) && !bus.proc_done));
  assign bus.rsp_valid = rsp_vld_q;
`ifdef LOADER_TIMEOUT_EN
  assign bus.rsp_timeout = rsp_tmo_q;
`else
  assign bus.rsp_timeout = 1'b0 & rsp_tmo_q;
`endif
endmodule

// File: tb/tb_tiny_proc_loader.sv
// Directed bench for tiny_proc_loader with a small processor-side frame capture model.
module tb_tiny_proc_loader;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  tiny_proc_loader_if bus ();

  tiny_proc_loader #(.GAP_CYCLES(2), .TIMEOUT(20), .TIMEOUT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor-side capture: commits a frame only if all 12 bits arrived.
  logic [11:0] sh;
  int          scnt = 0;
  logic        sel_was_d = 1'b0;
  int          i_commits = 0;
  int          d_commits = 0;
  logic [3:0]  last_i_addr = '0;
  logic [7:0]  last_i_data = '0;
  logic [3:0]  last_d_addr = '0;
  logic [7:0]  last_d_data = '0;
  int          rsp_cnt = 0;
  int          en_rises = 0;
  logic        en_prev = 1'b0;

  always @(posedge clk) begin
    en_prev <= bus.proc_en;
    if (bus.proc_en && !en_prev) en_rises <= en_rises + 1;
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (!bus.csi_n || !bus.csd_n) begin
      sh        <= {bus.mosi, sh[11:1]};
      scnt      <= scnt + 1;
      sel_was_d <= !bus.csd_n;
    end else begin
      scnt <= 0;
      if (scnt == 12) begin
        if (sel_was_d) begin
          d_commits   <= d_commits + 1;
          last_d_addr <= sh[3:0];
          last_d_data <= sh[11:4];
        end else begin
          i_commits   <= i_commits + 1;
          last_i_addr <= sh[3:0];
          last_i_data <= sh[11:4];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a write and check every cycle through to the response.
  task automatic do_write(input logic [1:0] op, input logic [3:0] a,
                          input logic [7:0] d, input logic [11:0] exp_frame);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("shift_mosi", {31'd0, bus.mosi}, {31'd0, exp_frame[i]});
      chk("shift_csi_n", {31'd0, bus.csi_n}, (op == 2'b00) ? 32'd0 : 32'd1);
      chk("shift_csd_n", {31'd0, bus.csd_n}, (op == 2'b01) ? 32'd0 : 32'd1);
      chk("shift_ready", {31'd0, bus.cmd_ready}, 32'd0);
      tick();
    end
    for (int g = 0; g < 2; g++) begin
      chk("gap_cs", {30'd0, bus.csi_n, bus.csd_n}, 32'd3);
      chk("gap_mosi", {31'd0, bus.mosi}, 32'd0);
      chk("gap_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      tick();
    end
    chk("wr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("wr_rsp_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
    chk("wr_ready", {31'd0, bus.cmd_ready}, 32'd1);
    tick();
    chk("wr_rsp_pulse", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    int r0;
    int e0;
    int i0;
    logic [11:0] prog_frame [4];
    prog_frame[0] = 12'h110;
    prog_frame[1] = 12'h221;
    prog_frame[2] = 12'h332;
    prog_frame[3] = 12'h443;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 4'h0;
    bus.cmd_data  = 8'h00;
    bus.proc_done = 1'b1;

    repeat (3) tick();
    chk("rst_cs", {30'd0, bus.csi_n, bus.csd_n}, 32'd3);
    chk("rst_mosi", {31'd0, bus.mosi}, 32'd0);
    chk("rst_proc_en", {31'd0, bus.proc_en}, 32'd0);
    chk("rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Instruction write addr 5 data A3: mosi 1,0,1,0,1,1,0,0,0,1,0,1
    do_write(2'b00, 4'h5, 8'hA3, 12'hA35);
    chk("icache_cnt", i_commits, 32'd1);
    chk("icache_addr", {28'd0, last_i_addr}, 32'h5);
    chk("icache_data", {24'd0, last_i_data}, 32'hA3);

    // Data write addr F data 80: mosi 1,1,1,1,0,0,0,0,0,0,0,1
    do_write(2'b01, 4'hF, 8'h80, 12'h80F);
    chk("dcache_cnt", d_commits, 32'd1);
    chk("dcache_addr", {28'd0, last_d_addr}, 32'hF);
    chk("dcache_data", {24'd0, last_d_data}, 32'h80);
    chk("icache_cnt2", i_commits, 32'd1);

    // No-op responds next cycle
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    tick();
    bus.cmd_valid = 1'b0;
    chk("nop_rsp", {31'd0, bus.rsp_valid}, 32'd1);
    chk("nop_tmo", {31'd0, bus.rsp_timeout}, 32'd0);
    chk("nop_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("nop_pins", {29'd0, bus.csi_n, bus.csd_n, bus.proc_en}, 32'd6);
    tick();
    chk("nop_pulse", {31'd0, bus.rsp_valid}, 32'd0);

    // 4-instruction program
    for (int p = 0; p < 4; p++)
      do_write(2'b00, prog_frame[p][3:0], prog_frame[p][11:4], prog_frame[p]);
    chk("prog_commits", i_commits, 32'd5);
    chk("prog_last", {20'd0, last_i_data, last_i_addr}, 32'h443);

    // Run: proc_done low for 6 cycles
    r0 = rsp_cnt;
    e0 = en_rises;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    tick();
    bus.cmd_valid = 1'b0;
    chk("run_en_k1", {31'd0, bus.proc_en}, 32'd1);
    chk("run_cs", {30'd0, bus.csi_n, bus.csd_n}, 32'd3);
    chk("run_ready", {31'd0, bus.cmd_ready}, 32'd0);
    tick();
    bus.proc_done = 1'b0;
    #1;
    chk("run_en_busy", {31'd0, bus.proc_en}, 32'd1);
    for (int j = 2; j <= 6; j++) begin
      tick();
      chk("run_en_hold", {31'd0, bus.proc_en}, 32'd1);
      chk("run_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    tick();
    bus.proc_done = 1'b1;
    #1;
    chk("run_en_drop", {31'd0, bus.proc_en}, 32'd0);
    chk("run_no_rsp_yet", {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    chk("run_rsp", {31'd0, bus.rsp_valid}, 32'd1);
    chk("run_rsp_tmo", {31'd0, bus.rsp_timeout}, 32'd0);
    chk("run_en_after", {31'd0, bus.proc_en}, 32'd0);
    chk("run_ready_after", {31'd0, bus.cmd_ready}, 32'd1);
    repeat (5) tick();
    chk("run_en_idle", {31'd0, bus.proc_en}, 32'd0);
    chk("run_one_rsp", rsp_cnt - r0, 32'd1);
    chk("run_one_exec", en_rises - e0, 32'd1);

    // Reset at bit 6 of an instruction frame (addr 3, data 5C)
    r0 = rsp_cnt;
    i0 = i_commits;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 4'h3;
    bus.cmd_data  = 8'h5C;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (6) tick();
    chk("mid_bit6", {31'd0, bus.mosi}, 32'd1);
    chk("mid_csi_low", {31'd0, bus.csi_n}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_cs", {30'd0, bus.csi_n, bus.csd_n}, 32'd3);
    chk("mid_rst_mosi", {31'd0, bus.mosi}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("mid_no_rsp", rsp_cnt - r0, 32'd0);
    chk("mid_no_commit", i_commits - i0, 32'd0);
    do_write(2'b00, 4'h3, 8'h5C, 12'h5C3);
    chk("mid_next_commit", i_commits - i0, 32'd1);
    chk("mid_next_data", {20'd0, last_i_data, last_i_addr}, 32'h5C3);

`ifdef LOADER_TIMEOUT_EN
    // Watchdog: processor never finishes, TIMEOUT=20
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    tick();
    bus.cmd_valid = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (j == 1) bus.proc_done = 1'b0;
      #1;
      chk("tmo_en_hold", {31'd0, bus.proc_en}, 32'd1);
      tick();
    end
    chk("tmo_en_drop", {31'd0, bus.proc_en}, 32'd0);
    chk("tmo_rsp", {31'd0, bus.rsp_valid}, 32'd1);
    chk("tmo_flag", {31'd0, bus.rsp_timeout}, 32'd1);
    bus.proc_done = 1'b1;
    tick();
    chk("tmo_pulse", {30'd0, bus.rsp_valid, bus.rsp_timeout}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
